// File: rtl/byte_packer_buffer_if.sv
// rtl/byte_packer_buffer_if.sv - byte-in / packed-word-out stream bundle
interface byte_packer_buffer_if #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32
);
  localparam int RATIO = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int CW    = $clog2(RATIO) + 1;

  logic                    data_in_valid;
  logic [INPUT_WIDTH-1:0]  data_in;
  logic                    flush;
  logic                    data_out_ready;
  logic                    data_out_valid;
  logic [OUTPUT_WIDTH-1:0] data_out;
  logic [CW-1:0]           data_out_count;
  logic                    full;
  logic                    overflow;

  modport master (
    output data_in_valid, data_in, flush, data_out_ready,
    input  data_out_valid, data_out, data_out_count, full, overflow
  );

  modport slave (
    input  data_in_valid, data_in, flush, data_out_ready,
    output data_out_valid, data_out, data_out_count, full, overflow
  );
endinterface

// File: rtl/byte_packer_buffer.sv
// rtl/byte_packer_buffer.sv - packs narrow input words little-endian into wide words and buffers them
module byte_packer_buffer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int BUFFER_DEPTH = 256
) (
  input  logic                 clock,
  input  logic                 nreset,
  byte_packer_buffer_if.slave  bus
);
  localparam int RATIO = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int LW    = $clog2(RATIO);
  localparam int CW    = LW + 1;
  localparam int AW    = $clog2(BUFFER_DEPTH);
  localparam int EW    = CW + OUTPUT_WIDTH;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(BUFFER_DEPTH);

  logic [LW-1:0]           r_lane;
  logic [OUTPUT_WIDTH-1:0] r_partial;
  logic [OUTPUT_WIDTH-1:0] w_word;
  logic [CW-1:0]           w_count;
  logic                    w_done;

  logic [EW-1:0]           r_mem [BUFFER_DEPTH];
  logic [EW-1:0]           r_rd_q;
  logic                    r_rd_valid;
  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;
  logic [AW:0]             r_occ;
  logic                    r_overflow;

  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_out_data;
  logic [CW-1:0]           r_out_count;

  logic w_full, w_wr_en, w_xfer, w_out_load, w_rd_en, w_mem_has;

  always_comb begin
    w_word = r_partial;
    if (bus.data_in_valid) begin
      w_word[int'(r_lane)*INPUT_WIDTH +: INPUT_WIDTH] = bus.data_in;
    end
  end

  assign w_count = {1'b0, r_lane} + CW'(bus.data_in_valid);
  assign w_done  = (bus.data_in_valid && (r_lane == LW'(RATIO-1))) ||
                   (bus.flush && ((r_lane != '0) || bus.data_in_valid));

  always_ff @(posedge clock) begin
    if (nreset) begin
      r_lane    <= '0;
      r_partial <= '0;
    end else if (w_done) begin
      r_lane    <= '0;
      r_partial <= '0;
    end else if (bus.data_in_valid) begin
      r_lane    <= r_lane + LW'(1);
      r_partial <= w_word;
    end
  end

  // Occupancy counts the memory plus both read-ahead stages, so full is judged on the whole block.
  assign w_full     = (r_occ == DEPTH_V);
  assign w_wr_en    = w_done && !w_full && !nreset;
  assign w_xfer     = r_out_valid && bus.data_out_ready;
  assign w_out_load = !r_out_valid || w_xfer;
  assign w_mem_has  = (r_wptr != r_rptr);
  assign w_rd_en    = w_mem_has && (!r_rd_valid || w_out_load) && !nreset;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wptr[AW-1:0]] <= {w_count, w_word};
    end
    if (w_rd_en) begin
      r_rd_q <= r_mem[r_rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_done && w_full) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr_en, w_xfer})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_rd_en) begin
        r_rd_valid <= 1'b1;
      end else if (w_out_load) begin
        r_rd_valid <= 1'b0;
      end
      // Output register only moves when empty or transferring, which keeps data_out stable under stall.
      if (w_out_load) begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) begin
          {r_out_count, r_out_data} <= r_rd_q;
        end
      end
    end
  end

  assign bus.data_out_valid = r_out_valid;
  assign bus.data_out       = r_out_data;
  assign bus.data_out_count = r_out_count;
  assign bus.full           = w_full;
  assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_byte_packer_buffer.sv
// tb/tb_byte_packer_buffer.sv - scoreboard bench for byte_packer_buffer
module tb_byte_packer_buffer;
  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  byte_packer_buffer_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32)) bus ();

  byte_packer_buffer #(
    .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(32),
    .BUFFER_DEPTH(256)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .bus(bus)
  );

  logic [34:0] sb_q[$];
  logic [34:0] exp_w;
  logic [34:0] prev_word;
  logic        prev_stall = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (nreset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {28'd0, bus.data_out_valid, bus.data_out_count, bus.data_out},
                {28'd0, 1'b1, prev_word});
        if (bus.data_out_valid && bus.data_out_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h expected no word",
                     {bus.data_out_count, bus.data_out});
          end else begin
            exp_w = sb_q.pop_front();
            check("word", {29'd0, bus.data_out_count, bus.data_out}, {29'd0, exp_w});
          end
        end
        prev_stall = bus.data_out_valid && !bus.data_out_ready;
        prev_word  = {bus.data_out_count, bus.data_out};
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    bus.data_in_valid = 1'b1;
    bus.data_in       = b;
    bus.flush         = fl;
    step();
    bus.data_in_valid = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 3000) begin
      step();
      k++;
    end
    check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    repeat (6) step();
  endtask

  initial begin
    logic [1:0]  lane;
    logic [31:0] part;
    nreset = 1'b1;
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    bus.flush = 1'b0;
    bus.data_out_ready = 1'b0;
    step();
    step();
    check("rst_valid", bus.data_out_valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_count", bus.data_out_count, 0);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    nreset = 1'b0;

    // basic pack with latency
    bus.data_out_ready = 1'b1;
    sb_q.push_back({3'd4, 32'h44332211});
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    step();
    check("lat_e4_valid", bus.data_out_valid, 0);
    step();
    check("lat_e5_valid", bus.data_out_valid, 1);
    check("lat_e5_data", bus.data_out, 32'h44332211);
    check("lat_e5_count", bus.data_out_count, 4);
    step();
    check("one_cycle_valid", bus.data_out_valid, 0);
    drain("basic");

    // flush cases
    sb_q.push_back({3'd2, 32'h0000BBAA});
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drain("flush2");
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drain("flush_empty");
    sb_q.push_back({3'd1, 32'h000000CC});
    send(8'hCC, 1'b1);
    drain("flush1");
    sb_q.push_back({3'd4, 32'h04030201});
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    drain("flush4");

    // fill to full, then overflow
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (i % 4 == 3)
        sb_q.push_back({3'd4, 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      send(8'(i), 1'b0);
    end
    check("full_set", bus.full, 1);
    check("full_no_ovf", bus.overflow, 0);
    check("full_head", bus.data_out, 32'h03020100);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    check("ovf_set", bus.overflow, 1);
    check("ovf_still_full", bus.full, 1);
    bus.data_out_ready = 1'b1;
    step();
    check("full_drop", bus.full, 0);
    drain("full");
    check("ovf_sticky", bus.overflow, 1);

    // back-to-back drain of 8 words
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 3)
        sb_q.push_back({3'd4, 8'(8'h80 + i), 8'(8'h80 + i - 1), 8'(8'h80 + i - 2), 8'(8'h80 + i - 3)});
      send(8'(8'h80 + i), 1'b0);
    end
    repeat (4) step();
    bus.data_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", bus.data_out_valid, 1);
      step();
    end
    check("b2b_end", bus.data_out_valid, 0);
    drain("b2b");

    // random ready with continuous input
    lane = 2'd0;
    part = 32'd0;
    for (int i = 0; i < 200; i++) begin
      bus.data_out_ready = 1'($urandom_range(0, 1));
      part[8*lane +: 8] = 8'(i * 7 + 3);
      if (lane == 2'd3) begin
        sb_q.push_back({3'd4, part});
        part = 32'd0;
      end
      lane = lane + 2'd1;
      send(8'(i * 7 + 3), 1'b0);
    end
    bus.data_out_ready = 1'b1;
    drain("rand");

    // reset mid-stream
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 14; i++) send(8'(8'h40 + i), 1'b0);
    repeat (3) step();
    nreset = 1'b1;
    step();
    check("mid_rst_valid", bus.data_out_valid, 0);
    check("mid_rst_data", bus.data_out, 0);
    check("mid_rst_count", bus.data_out_count, 0);
    check("mid_rst_full", bus.full, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    nreset = 1'b0;
    bus.data_out_ready = 1'b1;
    sb_q.push_back({3'd4, 32'h8D7C6B5A});
    send(8'h5A, 1'b0);
    send(8'h6B, 1'b0);
    send(8'h7C, 1'b0);
    send(8'h8D, 1'b0);
    drain("reset_mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
